// File: rtl/traffic_phase_controller_if.sv
// Sensor/emergency inputs and lamp/status outputs of the traffic phase controller.
// master = sensor front-end / lamp driver side, slave = controller side.
interface traffic_phase_controller_if #(
    parameter int N_LANES          = 4,
    parameter int SENSORS_PER_LANE = 3
);
    logic [N_LANES*SENSORS_PER_LANE-1:0] ir_sensors;
    logic [N_LANES-1:0]                  emerg_req;
    logic [3*N_LANES-1:0]                lights;
    logic [N_LANES-1:0]                  phase_mask;
    logic                                mode;
    logic                                emerg_active;

    modport master (
        output ir_sensors, emerg_req,
        input  lights, phase_mask, mode, emerg_active
    );

    modport slave (
        input  ir_sensors, emerg_req,
        output lights, phase_mask, mode, emerg_active
    );
endinterface

// File: rtl/traffic_phase_controller.sv
// N-lane intersection phase controller with density-selected single/paired rotation and emergency preemption.
// Optional green extension on occupied lanes is enabled by defining TRAFFIC_GREEN_EXT_EN.
module traffic_phase_controller #(
    parameter int N_LANES          = 4,
    parameter int SENSORS_PER_LANE = 3,
    parameter int GREEN_T          = 8,
    parameter int YELLOW_T         = 3,
    parameter int ALLRED_T         = 2,
    parameter int DENSITY_THRESH   = 6,
    parameter int MAX_EXT          = 4
) (
    input logic                  clk,
    input logic                  reset,
    traffic_phase_controller_if.slave bus
);
    localparam int TMAX_GY = (GREEN_T > YELLOW_T) ? GREEN_T : YELLOW_T;
    localparam int TMAX    = (TMAX_GY > ALLRED_T) ? TMAX_GY : ALLRED_T;
    localparam int TW      = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int LW      = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int IRW     = N_LANES * SENSORS_PER_LANE;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    typedef enum logic [1:0] {ST_GREEN, ST_YELLOW, ST_ALLRED, ST_EMERG} state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [LW-1:0]        last_lane_q, last_lane_d;
    logic [LW-1:0]        emerg_lane_q, emerg_lane_d;
    logic                 mode_q, mode_d;
    logic [3*N_LANES-1:0] lights_q, lights_d;
    logic [N_LANES-1:0]   phase_mask_q, phase_mask_d;
    logic                 emerg_active_q, emerg_active_d;

`ifdef TRAFFIC_GREEN_EXT_EN
    localparam int EW = (MAX_EXT > 0) ? $clog2(MAX_EXT + 1) : 1;
    logic [EW-1:0] ext_q, ext_d;
    logic          occupied;
`endif

    logic          emerg_any;
    logic [LW-1:0] target;
    logic [31:0]   pop_cnt;
    logic          dense;
    logic [LW-1:0] next_single;
    logic [LW-1:0] next_pair;
    logic          to_yellow;

    function automatic logic [3*N_LANES-1:0] paint(input logic [N_LANES-1:0] m, input logic [2:0] on);
        logic [3*N_LANES-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            r[3*i +: 3] = m[i] ? on : LAMP_RED;
        end
        return r;
    endfunction

    always_comb begin
        emerg_any = |bus.emerg_req;
        target    = '0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (bus.emerg_req[i]) target = LW'(i);
        end
        pop_cnt = '0;
        for (int unsigned i = 0; i < IRW; i++) begin
            pop_cnt = pop_cnt + 32'(bus.ir_sensors[i]);
        end
        dense       = (pop_cnt >= 32'(DENSITY_THRESH));
        next_single = LW'((int'(last_lane_q) + 1) % N_LANES);
        next_pair   = LW'(2 * ((int'(last_lane_q) / 2 + 1) % (N_LANES / 2)));
`ifdef TRAFFIC_GREEN_EXT_EN
        occupied = 1'b0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            if (phase_mask_q[i] && (|bus.ir_sensors[i*SENSORS_PER_LANE +: SENSORS_PER_LANE]))
                occupied = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        last_lane_d    = last_lane_q;
        emerg_lane_d   = emerg_lane_q;
        mode_d         = mode_q;
        lights_d       = lights_q;
        phase_mask_d   = phase_mask_q;
        emerg_active_d = emerg_active_q;
        to_yellow      = 1'b0;
`ifdef TRAFFIC_GREEN_EXT_EN
        ext_d          = ext_q;
`endif
        case (state_q)
            ST_GREEN: begin
                if (emerg_any) begin
                    // Only a single-lane phase already serving the target can hand over without clearance.
                    if (mode_q && (phase_mask_q == (N_LANES'(1) << target))) begin
                        state_d        = ST_EMERG;
                        emerg_lane_d   = target;
                        emerg_active_d = 1'b1;
                    end else begin
                        to_yellow = 1'b1;
                    end
                end else if (timer_q == '0) begin
`ifdef TRAFFIC_GREEN_EXT_EN
                    if (occupied && (ext_q < EW'(MAX_EXT))) ext_d = ext_q + 1'b1;
                    else                                     to_yellow = 1'b1;
`else
                    to_yellow = 1'b1;
`endif
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_YELLOW: begin
                if (timer_q == '0) begin
                    state_d      = ST_ALLRED;
                    timer_d      = TW'(ALLRED_T - 1);
                    lights_d     = paint('0, LAMP_GREEN);
                    phase_mask_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_ALLRED: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if (emerg_any) begin
                    state_d        = ST_EMERG;
                    emerg_lane_d   = target;
                    emerg_active_d = 1'b1;
                    phase_mask_d   = N_LANES'(1) << target;
                    lights_d       = paint(N_LANES'(1) << target, LAMP_GREEN);
                end else begin
                    state_d      = ST_GREEN;
                    timer_d      = TW'(GREEN_T - 1);
                    mode_d       = dense;
                    last_lane_d  = dense ? next_single : next_pair;
                    phase_mask_d = dense ? (N_LANES'(1) << next_single) : (N_LANES'(3) << next_pair);
                    lights_d     = paint(dense ? (N_LANES'(1) << next_single) : (N_LANES'(3) << next_pair),
                                         LAMP_GREEN);
`ifdef TRAFFIC_GREEN_EXT_EN
                    ext_d        = '0;
`endif
                end
            end
            ST_EMERG: begin
                if (!bus.emerg_req[emerg_lane_q]) to_yellow = 1'b1;
            end
            default: begin
                state_d      = ST_ALLRED;
                timer_d      = TW'(ALLRED_T - 1);
                lights_d     = paint('0, LAMP_GREEN);
                phase_mask_d = '0;
            end
        endcase

        if (to_yellow) begin
            state_d        = ST_YELLOW;
            timer_d        = TW'(YELLOW_T - 1);
            lights_d       = paint(phase_mask_q, LAMP_YELLOW);
            emerg_active_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_ALLRED;
            timer_q        <= TW'(ALLRED_T - 1);
            last_lane_q    <= LW'(N_LANES - 1);
            emerg_lane_q   <= '0;
            mode_q         <= 1'b0;
            lights_q       <= paint('0, LAMP_GREEN);
            phase_mask_q   <= '0;
            emerg_active_q <= 1'b0;
`ifdef TRAFFIC_GREEN_EXT_EN
            ext_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            last_lane_q    <= last_lane_d;
            emerg_lane_q   <= emerg_lane_d;
            mode_q         <= mode_d;
            lights_q       <= lights_d;
            phase_mask_q   <= phase_mask_d;
            emerg_active_q <= emerg_active_d;
`ifdef TRAFFIC_GREEN_EXT_EN
            ext_q          <= ext_d;
`endif
        end
    end

    assign bus.lights       = lights_q;
    assign bus.phase_mask   = phase_mask_q;
    assign bus.mode         = mode_q;
    assign bus.emerg_active = emerg_active_q;
endmodule

// File: tb/tb_traffic_phase_controller.sv
// Randomized scoreboard bench for traffic_phase_controller against a phase-level reference model.
module tb_traffic_phase_controller;
    localparam int N   = 4;
    localparam int SPL = 3;
    localparam int GT  = 8;
    localparam int YT  = 3;
    localparam int AT  = 2;
    localparam int DT  = 6;
    localparam int MX  = 4;
    localparam int CYCLES = 3000;

    localparam int PH_GREEN  = 0;
    localparam int PH_YELLOW = 1;
    localparam int PH_ALLRED = 2;
    localparam int PH_EMERG  = 3;

    typedef struct packed {
        logic [3*N-1:0] lights;
        logic [N-1:0]   mask;
        logic           mode;
        logic           emerg;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    traffic_phase_controller_if #(.N_LANES(N), .SENSORS_PER_LANE(SPL)) bus_if ();

    traffic_phase_controller #(
        .N_LANES(N), .SENSORS_PER_LANE(SPL), .GREEN_T(GT), .YELLOW_T(YT),
        .ALLRED_T(AT), .DENSITY_THRESH(DT), .MAX_EXT(MX)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus_if)
    );

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: phase kind, cycles left in it, set of lanes shown, rotation pointer.
    int m_ph, m_left, m_mask, m_last, m_mode, m_elane, m_ext;

    function automatic void model_reset();
        m_ph = PH_ALLRED; m_left = AT; m_mask = 0; m_last = N - 1;
        m_mode = 0; m_elane = 0; m_ext = 0;
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        o = '0;
        for (int i = 0; i < N; i++) begin
            if ((m_mask >> i) & 1) o.lights[3*i +: 3] = (m_ph == PH_YELLOW) ? 3'b010 : 3'b001;
            else                   o.lights[3*i +: 3] = 3'b100;
        end
        o.mask  = N'(m_mask);
        o.mode  = m_mode[0];
        o.emerg = (m_ph == PH_EMERG);
        return o;
    endfunction

    function automatic void model_step(input logic [N*SPL-1:0] ir, input logic [N-1:0] er);
        int tgt, busy;
        tgt = 0;
        for (int i = N - 1; i >= 0; i--) if (er[i]) tgt = i;
        case (m_ph)
            PH_GREEN: begin
                busy = 0;
                for (int i = 0; i < N; i++)
                    if (((m_mask >> i) & 1) && (ir[i*SPL +: SPL] != 0)) busy = 1;
                if (er != 0) begin
                    if (m_mode == 1 && m_mask == (1 << tgt)) begin
                        m_ph = PH_EMERG; m_elane = tgt;
                    end else begin
                        m_ph = PH_YELLOW; m_left = YT;
                    end
                end else if (m_left > 1) begin
                    m_left--;
`ifdef TRAFFIC_GREEN_EXT_EN
                end else if (busy == 1 && m_ext < MX) begin
                    m_ext++;
`endif
                end else begin
                    m_ph = PH_YELLOW; m_left = YT;
                end
            end
            PH_YELLOW: begin
                if (m_left > 1) m_left--;
                else begin m_ph = PH_ALLRED; m_left = AT; m_mask = 0; end
            end
            PH_ALLRED: begin
                if (m_left > 1) m_left--;
                else if (er != 0) begin
                    m_ph = PH_EMERG; m_elane = tgt; m_mask = 1 << tgt;
                end else begin
                    m_mode = ($countones(ir) >= DT) ? 1 : 0;
                    if (m_mode == 1) begin
                        m_last = (m_last + 1) % N;
                        m_mask = 1 << m_last;
                    end else begin
                        m_last = 2 * ((m_last / 2 + 1) % (N / 2));
                        m_mask = 3 << m_last;
                    end
                    m_ph = PH_GREEN; m_left = GT; m_ext = 0;
                end
            end
            default: begin
                if (!er[m_elane]) begin m_ph = PH_YELLOW; m_left = YT; end
            end
        endcase
    endfunction

    // Monitor: every edge with a pending expectation is compared.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus_if.lights, bus_if.phase_mask, bus_if.mode, bus_if.emerg_active};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: got lights=%h mask=%b mode=%b emerg=%b, want lights=%h mask=%b mode=%b emerg=%b",
                             $time, a.lights, a.mask, a.mode, a.emerg, e.lights, e.mask, e.mode, e.emerg);
                end
            end
        end
    end

    initial begin
        logic [N*SPL-1:0] ir;
        logic [N-1:0]     er;
        obs_t             e, a;
        int               e_hold, did_async, release_rst;

        ir = '0; er = '0; e_hold = 0; did_async = 0; release_rst = 0;
        reset = 1'b1;
        bus_if.ir_sensors = '0;
        bus_if.emerg_req  = '0;
        model_reset();

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clk);
            if (cyc == 1 || release_rst == 1) begin
                reset = 1'b0;
                release_rst = 0;
            end

            if (cyc < 40) begin
                ir = '0; er = '0;
            end else begin
                case ($urandom_range(0, 3))
                    0:       ir = '0;
                    1:       ir = (N*SPL)'($urandom);
                    2:       ir = '1;
                    default: ir = (N*SPL)'($urandom & $urandom);
                endcase
                if (e_hold > 0) begin
                    e_hold--;
                    if ($urandom_range(0, 9) == 0) er = N'($urandom_range(1, (1 << N) - 1));
                end else if ($urandom_range(0, 29) == 0) begin
                    er = N'($urandom_range(1, (1 << N) - 1));
                    e_hold = $urandom_range(3, 40);
                end else begin
                    er = '0;
                end
            end
            bus_if.ir_sensors = ir;
            bus_if.emerg_req  = er;

            // Asynchronous reset while the lamps show yellow must clear them without a clock edge.
            if (did_async == 0 && cyc > 1500 && m_ph == PH_YELLOW && reset == 1'b0) begin
                reset = 1'b1;
                did_async = 1;
                release_rst = 1;
                model_reset();
                #1;
                e = model_out();
                a = {bus_if.lights, bus_if.phase_mask, bus_if.mode, bus_if.emerg_active};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL async_reset @%0t: got lights=%h mask=%b mode=%b emerg=%b, want lights=%h mask=%b mode=%b emerg=%b",
                             $time, a.lights, a.mask, a.mode, a.emerg, e.lights, e.mask, e.mode, e.emerg);
                end
            end

            if (reset) model_reset();
            else       model_step(ir, er);
            exp_q.push_back(model_out());
        end

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        if (did_async == 0) begin
            miscompares++;
            $display("FAIL async_reset_reached: got 0 attempts, want 1");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
